// File: rtl/fft_pkg.sv
// Shared FFT pipeline constants, complex word type and the pairing-stage state encoding.
package fft_pkg;

    localparam int FLOAT_LEN    = 32;
    localparam int CPLX_W       = 2 * FLOAT_LEN;
    localparam int DATA_NUM     = 8192;
    localparam int SPAN_STAGE12 = 2048;

    typedef logic [CPLX_W-1:0] cplx_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PAIR
    } pair_state_t;

    // Index width that stays legal (>=1 bit) when a range collapses to a single entry.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pair_buf_ram.sv
// Synchronous-write / synchronous-read buffer holding the first half of each butterfly block.
module pair_buf_ram
    import fft_pkg::*;
#(
    parameter int DEPTH = SPAN_STAGE12,
    parameter int AW    = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CPLX_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [CPLX_W-1:0] rd_data
);

    logic [CPLX_W-1:0] mem [DEPTH];

    // NOTE: no reset on the array or its read register, so the tools can map it onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_stage12_pairer.sv
// FFT stage-12 butterfly pairer: buffers SPAN samples, pairs them with the next SPAN, paces the twiddle provider.
// Optional build macro STAGE12_ALIGN_CHECK_EN enables the sticky out_valid/tf_valid alignment check on err.
module fft_stage12_pairer
    import fft_pkg::*;
#(
    parameter int DATA_NUM = fft_pkg::DATA_NUM,
    parameter int SPAN     = SPAN_STAGE12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CPLX_W-1:0] in_data,
    output logic              tf_en,
    input  logic [CPLX_W-1:0] tf_data,
    input  logic              tf_valid,
    output logic              out_valid,
    output logic [CPLX_W-1:0] out_x1,
    output logic [CPLX_W-1:0] out_x2,
    output logic [CPLX_W-1:0] out_tf,
    output logic              frame_done,
    output logic              busy,
    output logic              err
);

    localparam int BLK_NUM = DATA_NUM / (2 * SPAN);
    localparam int CNT_W   = idx_width(SPAN);
    localparam int BLK_W   = idx_width(BLK_NUM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAN - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLK_NUM - 1);

    pair_state_t       state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [BLK_W-1:0]  blk, blk_n;
    logic              wr_en, rd_en, pair_last;
    logic [CPLX_W-1:0] rd_data;

    pair_buf_ram #(.DEPTH(SPAN), .AW(CNT_W)) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (cnt),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (cnt),
        .rd_data (rd_data)
    );

    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        blk_n     = blk;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        pair_last = 1'b0;
        unique case (state)
            IDLE: if (in_valid) begin
                wr_en = 1'b1;
                if (SPAN == 1) begin
                    state_n = PAIR;
                    cnt_n   = '0;
                end else begin
                    state_n = FILL;
                    cnt_n   = CNT_W'(1);
                end
            end
            FILL: if (in_valid) begin
                wr_en = 1'b1;
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = PAIR;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            PAIR: if (in_valid) begin
                rd_en = 1'b1;
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (blk == BLK_LAST) begin
                        blk_n     = '0;
                        state_n   = IDLE;
                        pair_last = 1'b1;
                    end else begin
                        blk_n   = blk + BLK_W'(1);
                        state_n = FILL;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            blk        <= '0;
            out_valid  <= 1'b0;
            out_x2     <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            blk        <= blk_n;
            out_valid  <= rd_en;
            frame_done <= pair_last;
            if (rd_en) out_x2 <= in_data;
        end
    end

    // One request per pair keeps the provider's free-running address in step with the pairs.
    assign tf_en  = rd_en;
    assign busy   = (state != IDLE);
    assign out_tf = tf_data;
    // The buffer's read register is unreset; mask it so out_x1 reads 0 out of reset.
    assign out_x1 = out_valid ? rd_data : '0;

`ifdef STAGE12_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        err <= 1'b0;
        else if (out_valid != tf_valid) err <= 1'b1;
    end
`else
    logic unused_tf_valid;
    assign unused_tf_valid = tf_valid;
    assign err             = 1'b0;
`endif

endmodule
